weight_fetch_sequencer: RTL and testbench

//  Initiator for the single-port weight ROM (read/addr -> dout, 1-cycle read latency).

---
 rtl/weight_fetch_pkg.sv | 15 +
 rtl/weight_skid_fifo.sv | 53 +++++
 rtl/weight_fetch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_weight_fetch_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_fetch_pkg.sv
// Shared types for the weight fetch sequencer.
//   wf_state_t : sequencer FSM state (IDLE -> FETCH -> DRAIN -> IDLE)
//   BUF_DEPTH  : entries in the output skid buffer; the issue credit rule
//                counts buffered plus in-flight words against this depth.
package weight_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } wf_state_t;

    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO holding {weight word, last flag} between the ROM read port
// and the downstream stream.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push, din  : write one entry (caller guarantees it is not full, or pops
//                in the same cycle)
//   pop, dout  : remove head entry; dout always shows the head
//   occ        : entries currently stored (0..2)
//   empty      : occ == 0
module weight_skid_fifo
    import weight_fetch_pkg::*;
#(
    parameter int DWIDTH = 72
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [DWIDTH:0] din,
    output logic [DWIDTH:0] dout,
    output logic [1:0]      occ,
    output logic            empty
);

    logic [DWIDTH:0] mem [BUF_DEPTH];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      occ_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ_q  <= 2'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout  = mem[rd_ptr];
    assign occ   = occ_q;
    assign empty = (occ_q == 2'd0);

endmodule

// File: rtl/weight_fetch_sequencer.sv
// Burst reader for the single-port weight ROM (1-cycle read latency).
// Accepts a (base_addr, burst_len) command, issues burst_len sequential ROM
// reads (address wraps modulo 2^AWIDTH) and returns the words in address
// order on a valid/ready stream with a last flag.
//   clk, rst_n           : clock, synchronous active-low reset
//   start, base_addr,
//   burst_len            : command; accepted only while busy=0; len 0 is legal
//   busy, done           : burst in progress / one-cycle completion pulse
//   mem_read, mem_addr,
//   mem_dout             : ROM port; mem_dout valid the cycle after mem_read
//   w_valid, w_ready,
//   w_data, w_last       : weight stream to the convolution engine
//   dbg_state            : current FSM state, for observation only
//
// Stream handshake: a word transfers on a rising edge where w_valid and
// w_ready are both 1. Once w_valid is raised, w_data and w_last stay stable
// and w_valid stays high until that transfer; w_valid never depends on
// w_ready.
module weight_fetch_sequencer
    import weight_fetch_pkg::*;
#(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 72,
    parameter int LWIDTH = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [LWIDTH-1:0] burst_len,
    output logic              busy,
    output logic              done,
    output logic              mem_read,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_dout,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DWIDTH-1:0] w_data,
    output logic              w_last,
    output wf_state_t         dbg_state
);

    wf_state_t         state_q, state_d;
    logic [AWIDTH-1:0] addr_q;
    logic [LWIDTH-1:0] remain_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              done_q;

    logic              issue;
    logic              last_issue;
    logic              start_zero;
    logic              last_pop;
    logic              pop;
    logic [2:0]        credit;

    logic [DWIDTH:0]   fifo_dout;
    logic [1:0]        fifo_occ;
    logic              fifo_empty;

    assign w_valid = ~fifo_empty;
    assign pop     = w_valid & w_ready;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and read issue. The credit term counts words that will
    // still occupy the buffer after this cycle's pop, including the read
    // already in flight; a new read is allowed only while that stays below
    // the buffer depth, so the buffer can never be pushed when full.
    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        last_issue = 1'b0;
        start_zero = 1'b0;
        last_pop   = 1'b0;
        credit     = {1'b0, fifo_occ} + {2'b00, inflight_q} - {2'b00, pop};
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (burst_len == '0) begin
                        start_zero = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (credit < 3'(BUF_DEPTH)) begin
                    issue = 1'b1;
                    if (remain_q == LWIDTH'(1)) begin
                        last_issue = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The final word can only reach the buffer after FETCH has
                // been left, so the last handshake is only seen here.
                if (pop && fifo_dout[0]) begin
                    last_pop = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address/remaining counters, in-flight tracking and done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q          <= '0;
            remain_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= last_issue;
            done_q          <= start_zero | last_pop;
            if (state_q == IDLE && start && burst_len != '0) begin
                addr_q   <= base_addr;
                remain_q <= burst_len;
            end else if (issue) begin
                addr_q   <= addr_q + AWIDTH'(1);
                remain_q <= remain_q - LWIDTH'(1);
            end
        end
    end

    // ROM data lands in the buffer on the edge ending the cycle after its
    // read; the last flag travels alongside it.
    weight_skid_fifo #(
        .DWIDTH (DWIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .pop   (pop),
        .din   ({mem_dout, inflight_last_q}),
        .dout  (fifo_dout),
        .occ   (fifo_occ),
        .empty (fifo_empty)
    );

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign mem_read  = issue;
    assign mem_addr  = addr_q;
    assign w_data    = fifo_dout[DWIDTH:1];
    assign w_last    = fifo_dout[0] & w_valid;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
module tb_weight_fetch_sequencer;
    import weight_fetch_pkg::*;

    localparam int AW = 16;
    localparam int DW = 72;
    localparam int LW = 17;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] burst_len = '0;
    logic          busy, done, mem_read, w_valid, w_last;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] w_data;
    logic [DW-1:0] rom_dout = '0;
    logic          w_ready = 1'b1;
    wf_state_t     dbg_state;

    weight_fetch_sequencer #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_dout  (rom_dout),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_last    (w_last),
        .dbg_state (dbg_state)
    );

    // ROM model: mem[i] = i, output held while read is low
    always @(posedge clk) begin
        if (mem_read) rom_dout <= {56'd0, mem_addr};
    end

    // ---------------- scoreboard bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- ready driver ----------------
    int ready_mode = 0;   // 0: always ready, 1: pattern 1,0,0,1
    int ready_ph = 0;
    logic [3:0] ready_pat = 4'b1001;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                w_ready = 1'b1;
            end else begin
                w_ready = ready_pat[3 - (ready_ph % 4)];
                ready_ph++;
            end
        end
    end

    // ---------------- behavioural model + compare process ----------------
    // A burst is a list of words {last, address} queued when the command is
    // accepted; the stream must emit exactly that list in order. Reads must
    // walk the same addresses, and words read but not yet handed downstream
    // may never exceed two.
    logic [AW:0]   exp_q[$];
    logic [AW-1:0] got_q[$];
    int            got_cyc[$];
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic [AW-1:0] m_addr = '0;
    int            m_left = 0;
    int            m_out = 0;
    int            e_s = 0;          // edge that raised start
    int            first_valid = -1; // edges from e_s to first w_valid

    initial begin
        logic nd;
        logic busy_now;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 1'b0;
                m_done = 1'b0;
                m_left = 0;
                m_out  = 0;
                exp_q.delete();
            end else begin
                nd = 1'b0;
                busy_now = m_busy;
                chk("busy", 80'(busy), 80'(m_busy));
                chk("done", 80'(done), 80'(m_done));
                if (mem_read) begin
                    chk("read_in_burst", 80'(m_busy && m_left > 0), 80'(1));
                    chk("mem_addr", 80'(mem_addr), 80'(m_addr));
                    m_addr = m_addr + 16'd1;
                    m_left--;
                    m_out++;
                end
                if (w_valid && w_ready) m_out--;
                if (mem_read) chk("outstanding_le_2", 80'(m_out <= 2), 80'(1));
                if (w_valid) begin
                    if (first_valid < 0) first_valid = cyc - e_s;
                    if (exp_q.size() == 0) begin
                        chk("w_valid_extra", 80'(w_valid), 80'(0));
                    end else begin
                        chk("w_data", 80'(w_data), {8'd0, 56'd0, exp_q[0][AW-1:0]});
                        chk("w_last", 80'(w_last), 80'(exp_q[0][AW]));
                        if (w_ready) begin
                            got_q.push_back(w_data[AW-1:0]);
                            got_cyc.push_back(cyc);
                            if (exp_q[0][AW]) begin
                                m_busy = 1'b0;
                                nd = 1'b1;
                            end
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (start && !busy_now) begin
                    if (burst_len == '0) begin
                        nd = 1'b1;
                    end else begin
                        m_busy = 1'b1;
                        m_addr = base_addr;
                        m_left = int'(burst_len);
                        for (int i = 0; i < int'(burst_len); i++) begin
                            exp_q.push_back({(i == int'(burst_len) - 1), 16'(int'(base_addr) + i)});
                        end
                    end
                end
                m_done = nd;
            end
        end
    end

    // ---------------- driver tasks ----------------
    int done_at;

    task automatic run_burst(input logic [AW-1:0] b, input logic [LW-1:0] l,
                             input int mode, input bit mid_start);
        bit seen;
        ready_mode = mode;
        ready_ph = 0;
        got_q.delete();
        got_cyc.delete();
        done_at = -1;
        @(posedge clk);
        #1;
        e_s = cyc;
        first_valid = -1;
        start = 1'b1;
        base_addr = b;
        burst_len = l;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (mid_start && k == 3) begin
                start = 1'b1;
                base_addr = 16'h0100;
                burst_len = 17'd3;
            end
            if (mid_start && k == 4) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                done_at = cyc - e_s;
            end
        end
        start = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done expected done within 300 cycles");
        end
        @(negedge clk);
        chk("queue_empty_after_done", 80'(exp_q.size()), 80'(0));
        ready_mode = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 80'(busy), 80'(0));
        chk({tag, "_done"}, 80'(done), 80'(0));
        chk({tag, "_mem_read"}, 80'(mem_read), 80'(0));
        chk({tag, "_w_valid"}, 80'(w_valid), 80'(0));
        chk({tag, "_w_last"}, 80'(w_last), 80'(0));
        chk({tag, "_mem_addr"}, 80'(mem_addr), 80'(0));
    endtask

    // ---------------- directed tests ----------------
    logic [AW-1:0] t3_exp [4];

    initial begin
        t3_exp[0] = 16'hFFFE;
        t3_exp[1] = 16'hFFFF;
        t3_exp[2] = 16'h0000;
        t3_exp[3] = 16'h0001;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // Test 1: base 0x10, len 4, always ready.
        // Start raised after edge e_s, sampled at e_s+1; first word visible
        // after e_s+3, four words back to back, done one cycle after the last.
        run_burst(16'h0010, 17'd4, 0, 1'b0);
        chk("t1_count", 80'(got_q.size()), 80'(4));
        if (got_q.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t1_word", 80'(got_q[i]), 80'(16'h0010 + i));
            chk("t1_back_to_back", 80'(got_cyc[3] - got_cyc[0]), 80'(3));
            chk("t1_done_after_last", 80'(e_s + done_at - got_cyc[3]), 80'(1));
        end
        chk("t1_first_valid", 80'(first_valid), 80'(3));
        chk("t1_done_at", 80'(done_at), 80'(7));

        // Test 2: base 0, len 8, ready pattern 1,0,0,1
        run_burst(16'h0000, 17'd8, 1, 1'b0);
        chk("t2_count", 80'(got_q.size()), 80'(8));
        if (got_q.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("t2_word", 80'(got_q[i]), 80'(i));
        end

        // Test 3: address wrap
        run_burst(16'hFFFE, 17'd4, 0, 1'b0);
        chk("t3_count", 80'(got_q.size()), 80'(4));
        if (got_q.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t3_word", 80'(got_q[i]), 80'(t3_exp[i]));
        end

        // Test 4: zero-length burst, done in the cycle after start
        run_burst(16'h0040, 17'd0, 0, 1'b0);
        chk("t4_done_at", 80'(done_at), 80'(1));
        chk("t4_count", 80'(got_q.size()), 80'(0));
        chk("t4_busy", 80'(busy), 80'(0));

        // Test 5: start pulsed mid-burst is ignored
        run_burst(16'h0030, 17'd8, 1, 1'b1);
        chk("t5_count", 80'(got_q.size()), 80'(8));
        if (got_q.size() == 8) begin
            chk("t5_first", 80'(got_q[0]), 80'(16'h0030));
            chk("t5_last", 80'(got_q[7]), 80'(16'h0037));
        end

        // Test 6: reset mid-burst after 3 words, then base 5 len 2
        ready_mode = 0;
        got_q.delete();
        got_cyc.delete();
        @(posedge clk);
        #1;
        e_s = cyc;
        start = 1'b1;
        base_addr = 16'h0020;
        burst_len = 17'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 50 && got_q.size() < 3; k++) @(negedge clk);
        chk("t6_words_before_reset", 80'(got_q.size() >= 3), 80'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6_after_reset");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t6_no_done", 80'(done), 80'(0));
        end
        run_burst(16'h0005, 17'd2, 0, 1'b0);
        chk("t6_count", 80'(got_q.size()), 80'(2));
        if (got_q.size() == 2) begin
            chk("t6_word0", 80'(got_q[0]), 80'(5));
            chk("t6_word1", 80'(got_q[1]), 80'(6));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got still running expected finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

endmodule
